// File: rtl/lcd_spi_write.sv
// lcd_spi_write
//   Serial transmit engine for the 9-bit LCD command/data word interface.
//   One word is accepted per request ({dc, byte}). The byte is shifted out
//   MSB-first on a 4-wire SPI bus in mode 0 (SCLK idles low, MOSI is stable
//   across every rising edge). A one-cycle wr_done pulse marks the end of
//   each frame. After the pulse, a short guard gap lets the producer update
//   data before the next request is sampled.
//
// Parameters
//   CLK_DIV  sys_clk cycles per SCLK half-period (1..255)
//   GAP_CYC  idle cycles after wr_done before en_write is sampled (0..15)
//
// Ports
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous active-low reset
//   en_write   in   write request, level-sensitive, sampled only in IDLE
//   data       in   [8] = dc (0 command, 1 data), [7:0] = byte
//   wr_done    out  one-cycle pulse when the frame is complete
//   busy       out  high whenever the engine is not idle
//   lcd_cs_n   out  chip select, active-low
//   lcd_dc     out  data/command select, held until the next latch
//   lcd_sclk   out  serial clock, idle low
//   lcd_mosi   out  serial data, MSB first
//
// Frame timing
//   The request is seen at edge n. The outputs for the frame then run as:
//   SETUP CLK_DIV cycles, SHIFT 16*CLK_DIV cycles, HOLD CLK_DIV cycles,
//   DONE 1 cycle, GAP GAP_CYC cycles.
//   All outputs are registered. Each transition writes the output values
//   of the state being entered.

module lcd_spi_write #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned GAP_CYC = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       en_write,
    input  logic [8:0] data,
    output logic       wr_done,
    output logic       busy,
    output logic       lcd_cs_n,
    output logic       lcd_dc,
    output logic       lcd_sclk,
    output logic       lcd_mosi
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE,
        GAP
    } state_t;

    // Terminal counts for the half-period and gap counters.
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

    state_t     state;
    logic [7:0] shreg;
    logic [7:0] div_cnt;
    logic [2:0] bit_cnt;
    logic [3:0] gap_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            wr_done  <= 1'b0;
            busy     <= 1'b0;
            lcd_cs_n <= 1'b1;
            lcd_dc   <= 1'b0;
            lcd_sclk <= 1'b0;
            lcd_mosi <= 1'b0;
        end else begin
            // wr_done is a single-cycle pulse. Only the HOLD exit raises it.
            wr_done <= 1'b0;

            case (state)
                IDLE: begin
                    lcd_cs_n <= 1'b1;
                    lcd_sclk <= 1'b0;
                    lcd_mosi <= 1'b0;
                    if (en_write) begin
                        // Latch the whole word. Later changes to data do
                        // not affect this frame. Bit 7 is presented on
                        // MOSI as soon as CS falls.
                        shreg    <= data[7:0];
                        lcd_dc   <= data[8];
                        lcd_mosi <= data[7];
                        lcd_cs_n <= 1'b0;
                        busy     <= 1'b1;
                        div_cnt  <= '0;
                        state    <= SETUP;
                    end
                end

                SETUP: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        bit_cnt <= 3'd7;
                        state   <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!lcd_sclk) begin
                            // End of low phase: rising edge, MOSI untouched.
                            lcd_sclk <= 1'b1;
                        end else begin
                            // End of high phase: falling edge. The next bit
                            // is presented here, so MOSI only ever changes
                            // while SCLK is low.
                            lcd_sclk <= 1'b0;
                            if (bit_cnt == 3'd0) begin
                                state <= HOLD;
                            end else begin
                                bit_cnt  <= bit_cnt - 3'd1;
                                shreg    <= shreg << 1;
                                lcd_mosi <= shreg[6];
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                HOLD: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        wr_done  <= 1'b1;
                        lcd_cs_n <= 1'b1;
                        lcd_mosi <= 1'b0;
                        state    <= DONE;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                DONE: begin
                    if (GAP_CYC == 0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end

                default: begin
                    busy     <= 1'b0;
                    lcd_cs_n <= 1'b1;
                    lcd_sclk <= 1'b0;
                    lcd_mosi <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_spi_write.sv
// Self-checking bench for lcd_spi_write. It uses two instances:
// instance 0 with the defaults (CLK_DIV=2, GAP_CYC=2) and instance 1 with
// CLK_DIV=1, GAP_CYC=0. A frame-offset model derives every output from
// the position within the frame. One compare process checks both
// instances on every cycle. Directed tests pin the model with literals,
// and then random traffic runs.

module tb_lcd_spi_write;

    localparam int DA = 2;
    localparam int GA = 2;
    localparam int DB = 1;
    localparam int GB = 0;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_w[2];
    logic [8:0] din[2];
    logic       wr_w[2], busy_w[2], cs_w[2], dc_w[2], sclk_w[2], mosi_w[2];

    always #5 clk = ~clk;

    lcd_spi_write #(.CLK_DIV(DA), .GAP_CYC(GA)) u_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .en_write(en_w[0]), .data(din[0]),
        .wr_done(wr_w[0]), .busy(busy_w[0]), .lcd_cs_n(cs_w[0]),
        .lcd_dc(dc_w[0]), .lcd_sclk(sclk_w[0]), .lcd_mosi(mosi_w[0])
    );

    lcd_spi_write #(.CLK_DIV(DB), .GAP_CYC(GB)) u_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .en_write(en_w[1]), .data(din[1]),
        .wr_done(wr_w[1]), .busy(busy_w[1]), .lcd_cs_n(cs_w[1]),
        .lcd_dc(dc_w[1]), .lcd_sclk(sclk_w[1]), .lcd_mosi(mosi_w[1])
    );

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int dval(input int i);
        return (i == 0) ? DA : DB;
    endfunction

    function automatic int gval(input int i);
        return (i == 0) ? GA : GB;
    endfunction

    // Expected {wr_done, busy, cs_n, dc, sclk, mosi} at frame offset k.
    // k = 0 is idle, and k = 1 is the first cycle after the latching edge.
    function automatic logic [5:0] exp_out(input int k, input logic [8:0] w,
                                           input logic dc, input int d);
        int   j, b;
        logic hi;
        if (k == 0)          return {3'b001, dc, 2'b00};
        if (k <= d)          return {3'b010, dc, 1'b0, w[7]};
        if (k <= 17 * d) begin
            j  = k - d - 1;
            b  = j / (2 * d);
            hi = (j % (2 * d)) >= d;
            return {3'b010, dc, hi, w[7 - b]};
        end
        if (k <= 18 * d)     return {3'b010, dc, 1'b0, w[0]};
        if (k == 18 * d + 1) return {3'b111, dc, 2'b00};
        return {3'b011, dc, 2'b00};
    endfunction

    // Frame-position model
    int         mk[2]  = '{0, 0};
    logic [8:0] mw[2]  = '{9'h0, 9'h0};
    logic       mdc[2] = '{1'b0, 1'b0};

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mk[i]  = 0;
                mw[i]  = '0;
                mdc[i] = 1'b0;
            end else if (mk[i] == 0) begin
                if (en_w[i]) begin
                    mw[i]  = din[i];
                    mdc[i] = din[i][8];
                    mk[i]  = 1;
                end
            end else if (mk[i] == 18 * dval(i) + 1 + gval(i)) begin
                mk[i] = 0;
            end else begin
                mk[i]++;
            end
        end
    end

    // Per-cycle compare
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("cycle_outputs[%0d]@k=%0d", i, mk[i]),
                {26'd0, wr_w[i], busy_w[i], cs_w[i], dc_w[i], sclk_w[i], mosi_w[i]},
                {26'd0, exp_out(mk[i], mw[i], mdc[i], dval(i))});
        end
    end

    // Frame monitor: records what the DUT put on the pins
    int         fall_cyc[2]  = '{0, 0};
    int         fall_cnt[2]  = '{0, 0};
    int         low_cnt[2]   = '{0, 0};
    int         rise_cyc[2]  = '{0, 0};
    int         period[2]    = '{0, 0};
    int         rises[2]     = '{0, 0};
    int         done_cnt[2]  = '{0, 0};
    int         done_cyc[2]  = '{0, 0};
    int         prev_done[2] = '{0, 0};
    int         done_low[2]  = '{0, 0};
    int         done_rise[2] = '{0, 0};
    logic [7:0] cap[2]       = '{8'h0, 8'h0};
    logic [7:0] done_byte[2] = '{8'h0, 8'h0};
    logic       done_dc[2]   = '{1'b0, 1'b0};
    logic       p_cs[2]      = '{1'b1, 1'b1};
    logic       p_sclk[2]    = '{1'b0, 1'b0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (p_cs[i] && !cs_w[i]) begin
                fall_cyc[i] = cyc;
                fall_cnt[i]++;
                low_cnt[i] = 1;
                rises[i]   = 0;
                cap[i]     = '0;
            end else if (!cs_w[i]) begin
                low_cnt[i]++;
            end
            if (!p_sclk[i] && sclk_w[i]) begin
                cap[i]      = {cap[i][6:0], mosi_w[i]};
                rises[i]++;
                period[i]   = cyc - rise_cyc[i];
                rise_cyc[i] = cyc;
            end
            if (wr_w[i]) begin
                prev_done[i] = done_cyc[i];
                done_cyc[i]  = cyc;
                done_cnt[i]++;
                done_byte[i] = cap[i];
                done_dc[i]   = dc_w[i];
                done_low[i]  = low_cnt[i];
                done_rise[i] = rises[i];
            end
            p_cs[i]   = cs_w[i];
            p_sclk[i] = sclk_w[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_pulse(input int i, input logic [8:0] w);
        din[i]  = w;
        en_w[i] = 1'b1;
        tick();
        en_w[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int cnt0, input int limit, input string name);
        int c = 0;
        while (done_cnt[i] == cnt0 && c < limit) begin
            @(posedge clk);
            c++;
        end
        #2;
        chk({name, "_done_seen"}, done_cnt[i] - cnt0, 1);
    endtask

    initial begin
        int c0, c1, f0, r0, r1, c;
        en_w = '{1'b0, 1'b0};
        din  = '{9'h0, 9'h0};
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outs_a", {26'd0, wr_w[0], busy_w[0], cs_w[0], dc_w[0], sclk_w[0], mosi_w[0]}, 32'b001000);
        chk("reset_outs_b", {26'd0, wr_w[1], busy_w[1], cs_w[1], dc_w[1], sclk_w[1], mosi_w[1]}, 32'b001000);
        chk("model_first_rise", {26'd0, exp_out(5, 9'h02C, 1'b0, DA)}, 32'b010010);
        chk("model_done", {26'd0, exp_out(37, 9'h02C, 1'b0, DA)}, 32'b111000);
        rst_n = 1'b1;
        repeat (2) tick();

        // Command frame 0x02C
        c0 = done_cnt[0];
        send_pulse(0, 9'h02C);
        wait_done(0, c0, 100, "t1");
        chk("t1_byte", done_byte[0], 8'h2C);
        chk("t1_dc", done_dc[0], 0);
        chk("t1_latency", done_cyc[0] - fall_cyc[0], 36);
        chk("t1_cs_low", done_low[0], 36);
        chk("t1_rises", done_rise[0], 8);
        chk("t1_period", period[0], 4);
        repeat (5) tick();

        // Back-to-back frames with en_write held high
        din[0]  = 9'h1BC;
        en_w[0] = 1'b1;
        c0 = done_cnt[0];
        wait_done(0, c0, 100, "t2a");
        din[0] = 9'h140;
        chk("t2a_byte", done_byte[0], 8'hBC);
        chk("t2a_dc", done_dc[0], 1);
        c1 = done_cnt[0];
        wait_done(0, c1, 100, "t2b");
        en_w[0] = 1'b0;
        chk("t2b_byte", done_byte[0], 8'h40);
        chk("t2b_dc", done_dc[0], 1);
        chk("t2_spacing", done_cyc[0] - prev_done[0], 40);
        repeat (5) tick();

        // Data changes during the frame
        c0 = done_cnt[0];
        send_pulse(0, 9'h0A5);
        repeat (4) tick();
        din[0] = 9'h15A;
        wait_done(0, c0, 100, "t3a");
        chk("t3a_byte", done_byte[0], 8'hA5);
        chk("t3a_dc", done_dc[0], 0);
        repeat (4) tick();
        c0 = done_cnt[0];
        send_pulse(0, din[0]);
        wait_done(0, c0, 100, "t3b");
        chk("t3b_byte", done_byte[0], 8'h5A);
        chk("t3b_dc", done_dc[0], 1);
        repeat (5) tick();

        // Reset asserted mid-SHIFT
        c0 = done_cnt[0];
        send_pulse(0, 9'h1A5);
        repeat (9) tick();
        chk("t4_busy_before", busy_w[0], 1);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_outs", {26'd0, wr_w[0], busy_w[0], cs_w[0], dc_w[0], sclk_w[0], mosi_w[0]}, 32'b001000);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("t4_no_done", done_cnt[0] - c0, 0);
        c0 = done_cnt[0];
        send_pulse(0, 9'h0FF);
        wait_done(0, c0, 100, "t4");
        chk("t4_byte", done_byte[0], 8'hFF);
        chk("t4_latency", done_cyc[0] - fall_cyc[0], 36);
        chk("t4_rises", done_rise[0], 8);
        repeat (5) tick();

        // CLK_DIV=1, GAP_CYC=0, en_write held high
        din[1]  = 9'h181;
        en_w[1] = 1'b1;
        c0 = done_cnt[1];
        wait_done(1, c0, 60, "t5");
        chk("t5_byte", done_byte[1], 8'h81);
        chk("t5_dc", done_dc[1], 1);
        chk("t5_latency", done_cyc[1] - fall_cyc[1], 18);
        chk("t5_period", period[1], 2);
        chk("t5_rises", done_rise[1], 8);
        f0 = fall_cnt[1];
        c  = 0;
        while (fall_cnt[1] == f0 && c < 20) begin
            @(posedge clk);
            c++;
        end
        #2;
        chk("t5_refall_seen", fall_cnt[1] - f0, 1);
        chk("t5_refall_gap", fall_cyc[1] - done_cyc[1], 2);
        en_w[1] = 1'b0;
        c1 = done_cnt[1];
        wait_done(1, c1, 60, "t5b");
        chk("t5b_byte", done_byte[1], 8'h81);
        repeat (5) tick();

        // Random traffic on both instances
        r0 = done_cnt[0];
        r1 = done_cnt[1];
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < 2; i++) begin
                en_w[i] = ($urandom_range(0, 3) != 0);
                din[i]  = 9'($urandom);
            end
            if (n == 2000) rst_n = 1'b0;
            if (n == 2003) rst_n = 1'b1;
            tick();
        end
        en_w = '{1'b0, 1'b0};
        chk("rand_frames_a", {31'd0, (done_cnt[0] - r0) > 50}, 1);
        chk("rand_frames_b", {31'd0, (done_cnt[1] - r1) > 100}, 1);
        repeat (50) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
